// File: rtl/aes_pkg.sv
// Shared AES key-schedule definitions: key-length encodings, per-length
// constants, FSM state type and GF(2^8) arithmetic helpers.
package aes_pkg;

    localparam logic [1:0] KL_128 = 2'b00;
    localparam logic [1:0] KL_192 = 2'b01;
    localparam logic [1:0] KL_256 = 2'b10;
    localparam logic [1:0] KL_ILL = 2'b11;

    localparam logic [3:0] NK_128 = 4'd4;
    localparam logic [3:0] NK_192 = 4'd6;
    localparam logic [3:0] NK_256 = 4'd8;

    localparam logic [3:0] NR_128 = 4'd10;
    localparam logic [3:0] NR_192 = 4'd12;
    localparam logic [3:0] NR_256 = 4'd14;

    // Words per expansion: 4*(Nr+1)
    localparam logic [5:0] NW_128 = 6'd44;
    localparam logic [5:0] NW_192 = 6'd52;
    localparam logic [5:0] NW_256 = 6'd60;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GEN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            p  = p ^ (b[k] ? aa : 8'h00);
            aa = xtime(aa);
        end
        return p;
    endfunction

    function automatic logic [3:0] nk_of(input logic [1:0] klen);
        case (klen)
            KL_192:  return NK_192;
            KL_256:  return NK_256;
            default: return NK_128;
        endcase
    endfunction

    function automatic logic [3:0] nr_of(input logic [1:0] klen);
        case (klen)
            KL_192:  return NR_192;
            KL_256:  return NR_256;
            default: return NR_128;
        endcase
    endfunction

    function automatic logic [5:0] nw_of(input logic [1:0] klen);
        case (klen)
            KL_192:  return NW_192;
            KL_256:  return NW_256;
            default: return NW_128;
        endcase
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES byte S-box: multiplicative inverse in GF(2^8)
// followed by the affine transform.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    // Inverse as a^254 via a fixed square-and-multiply chain; 0 maps to 0.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x6   = gf_mul(x3, x3);
        x12  = gf_mul(x6, x6);
        x15  = gf_mul(x12, x3);
        x30  = gf_mul(x15, x15);
        x60  = gf_mul(x30, x30);
        x120 = gf_mul(x60, x60);
        x240 = gf_mul(x120, x120);
        x252 = gf_mul(x240, x12);
        return gf_mul(x252, x2);
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    assign out_byte = affine(gf_inv(in_byte));

endmodule

// File: rtl/key_sched_ctrl.sv
// AES key-expansion controller: streams round keys 0..Nr for 128/192/256-bit
// keys over a valid/ready interface, one expanded word per cycle.
module key_sched_ctrl
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [1:0]   key_len,
    input  logic [0:255] key_in,
    output logic         busy,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [0:127] rk_data,
    output logic [3:0]   rk_idx,
    output logic         done,
    output logic         err
);

    state_e       state_q, state_d;
    logic [1:0]   klen_q, klen_d;
    logic [31:0]  key_w_q [8];
    logic [31:0]  key_w_d [8];
    logic [5:0]   widx_q, widx_d;
    logic [2:0]   wrap_q, wrap_d;
    logic [7:0]   rcon_q, rcon_d;
    logic [31:0]  win_q [8];
    logic [31:0]  win_d [8];
    logic [31:0]  asm_q [3];
    logic [31:0]  asm_d [3];
    logic [3:0]   kcnt_q, kcnt_d;
    logic         rk_valid_q, rk_valid_d;
    logic [0:127] rk_data_q, rk_data_d;
    logic [3:0]   rk_idx_q, rk_idx_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         err_q, err_d;

    logic [3:0]   nk_s;
    logic [2:0]   nk_m1_s;
    logic [5:0]   nw_s;
    logic         accept_s, xfer_s, stall_s, gen_go_s, last_word_s;
    logic [31:0]  sub_in_s, sub_out_s, w_new_s;
    logic         rcon_use_s;

    assign nk_s        = nk_of(klen_q);
    assign nk_m1_s     = 3'(nk_s - 4'd1);
    assign nw_s        = nw_of(klen_q);
    assign accept_s    = (state_q == ST_IDLE) && start && (key_len != KL_ILL);
    assign xfer_s      = rk_valid_q && rk_ready;
    // The fourth word of a round key cannot be produced while the previous key is still waiting.
    assign stall_s     = (widx_q[1:0] == 2'd3) && rk_valid_q && !rk_ready;
    assign gen_go_s    = (state_q == ST_GEN) && !stall_s;
    assign last_word_s = (widx_q == (nw_s - 6'd1));

    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sbox u_sbox (
            .in_byte  (sub_in_s[8*g +: 8]),
            .out_byte (sub_out_s[8*g +: 8])
        );
    end

    // Word generator: key words first, then the recurrence over the shift window.
    always_comb begin
        sub_in_s   = (wrap_q == 3'd0) ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];
        rcon_use_s = 1'b0;
        if (widx_q < {2'b00, nk_s}) begin
            w_new_s = key_w_q[wrap_q];
        end else if (wrap_q == 3'd0) begin
            w_new_s    = win_q[nk_m1_s] ^ sub_out_s ^ {rcon_q, 24'h000000};
            rcon_use_s = 1'b1;
        end else if ((nk_s == NK_256) && (wrap_q == 3'd4)) begin
            w_new_s = win_q[nk_m1_s] ^ sub_out_s;
        end else begin
            w_new_s = win_q[nk_m1_s] ^ win_q[0];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) state_d = ST_GEN;
                else          state_d = ST_IDLE;
            end
            ST_GEN: begin
                if (gen_go_s && last_word_s) state_d = ST_DRAIN;
                else                         state_d = ST_GEN;
            end
            ST_DRAIN: begin
                if (xfer_s) state_d = ST_IDLE;
                else        state_d = ST_DRAIN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath and output next values.
    always_comb begin
        klen_d     = klen_q;
        key_w_d    = key_w_q;
        widx_d     = widx_q;
        wrap_d     = wrap_q;
        rcon_d     = rcon_q;
        win_d      = win_q;
        asm_d      = asm_q;
        kcnt_d     = kcnt_q;
        rk_valid_d = rk_valid_q;
        rk_data_d  = rk_data_q;
        rk_idx_d   = rk_idx_q;
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_q == ST_DRAIN) && xfer_s;
        err_d      = (state_q == ST_IDLE) && start && (key_len == KL_ILL);

        if (accept_s) begin
            klen_d = key_len;
            widx_d = 6'd0;
            wrap_d = 3'd0;
            rcon_d = 8'h01;
            kcnt_d = 4'd0;
            for (int k = 0; k < 8; k++) begin
                key_w_d[k] = key_in[32*k +: 32];
                win_d[k]   = 32'h00000000;
            end
            for (int k = 0; k < 3; k++) begin
                asm_d[k] = 32'h00000000;
            end
        end else begin
            klen_d = klen_q;
        end

        if (xfer_s) begin
            rk_valid_d = 1'b0;
        end else begin
            rk_valid_d = rk_valid_q;
        end

        if (gen_go_s) begin
            widx_d   = widx_q + 6'd1;
            wrap_d   = (wrap_q == nk_m1_s) ? 3'd0 : wrap_q + 3'd1;
            win_d[0] = w_new_s;
            for (int k = 1; k < 8; k++) begin
                win_d[k] = win_q[k-1];
            end
            if (rcon_use_s) begin
                rcon_d = xtime(rcon_q);
            end else begin
                rcon_d = rcon_q;
            end
            case (widx_q[1:0])
                2'd0:    asm_d[0] = w_new_s;
                2'd1:    asm_d[1] = w_new_s;
                2'd2:    asm_d[2] = w_new_s;
                default: begin
                    rk_data_d  = {asm_q[0], asm_q[1], asm_q[2], w_new_s};
                    rk_idx_d   = kcnt_q;
                    kcnt_d     = kcnt_q + 4'd1;
                    rk_valid_d = 1'b1;
                end
            endcase
        end else begin
            widx_d = widx_d;
        end
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            klen_q     <= 2'b00;
            widx_q     <= 6'd0;
            wrap_q     <= 3'd0;
            rcon_q     <= 8'h00;
            kcnt_q     <= 4'd0;
            rk_valid_q <= 1'b0;
            rk_data_q  <= 128'h0;
            rk_idx_q   <= 4'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int k = 0; k < 8; k++) begin
                key_w_q[k] <= 32'h00000000;
                win_q[k]   <= 32'h00000000;
            end
            for (int k = 0; k < 3; k++) begin
                asm_q[k] <= 32'h00000000;
            end
        end else begin
            klen_q     <= klen_d;
            widx_q     <= widx_d;
            wrap_q     <= wrap_d;
            rcon_q     <= rcon_d;
            kcnt_q     <= kcnt_d;
            rk_valid_q <= rk_valid_d;
            rk_data_q  <= rk_data_d;
            rk_idx_q   <= rk_idx_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            key_w_q    <= key_w_d;
            win_q      <= win_d;
            asm_q      <= asm_d;
        end
    end

    assign busy     = busy_q;
    assign rk_valid = rk_valid_q;
    assign rk_data  = rk_data_q;
    assign rk_idx   = rk_idx_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Self-checking bench for key_sched_ctrl: known-answer vectors, backpressure,
// illegal length, mid-run reset and randomized keys against a reference model.
module tb_key_sched_ctrl;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [1:0]   key_len;
    logic [255:0] key_in;
    logic         busy;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_data;
    logic [3:0]   rk_idx;
    logic         done;
    logic         err;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0]   sbox_t [256];
    logic [7:0]   rcon_t [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
    logic [127:0] exp_keys [15];
    logic [127:0] got_keys [15];
    int           exp_n;
    int           got_n;

    key_sched_ctrl dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_len  (key_len),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_ready (rk_ready),
        .rk_data  (rk_data),
        .rk_idx   (rk_idx),
        .done     (done),
        .err      (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] acc;
        acc = 16'h0;
        for (int k = 0; k < 8; k++)
            if (b[k]) acc = acc ^ (16'(a) << k);
        for (int k = 15; k >= 8; k--)
            if (acc[k]) acc = acc ^ (16'h011b << (k - 8));
        return acc[7:0];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s, c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int b = 0; b < 8; b++)
                s[b] = inv[b] ^ inv[(b+4)%8] ^ inv[(b+5)%8] ^ inv[(b+6)%8] ^ inv[(b+7)%8] ^ c[b];
            sbox_t[x] = s;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] t);
        return {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
    endfunction

    task automatic model_expand(input logic [1:0] kl, input logic [255:0] key);
        int nk, nr;
        logic [31:0] w [60];
        logic [31:0] t;
        nk = (kl == 2'd0) ? 4 : (kl == 2'd1) ? 6 : 8;
        nr = nk + 6;
        for (int i = 0; i < 4*(nr+1); i++) begin
            if (i < nk) begin
                w[i] = key[255-32*i -: 32];
            end else begin
                t = w[i-1];
                if (i % nk == 0)
                    t = subw({t[23:0], t[31:24]}) ^ {rcon_t[i/nk-1], 24'h0};
                else if (nk == 8 && i % nk == 4)
                    t = subw(t);
                w[i] = w[i-nk] ^ t;
            end
        end
        exp_n = nr + 1;
        for (int r = 0; r <= nr; r++)
            exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_valid"}, rk_valid, 0);
        chk({tag, "_data"},  rk_data, 0);
        chk({tag, "_idx"},   rk_idx, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_err"},   err, 0);
    endtask

    // mode 0: ready high; 1: ready low 10 cycles after first valid then random;
    // 2: random ready. Modes 1/2 also inject start noise that must be ignored.
    task automatic run_exp(input logic [1:0] kl, input logic [255:0] key,
                           input int mode, input int abort_k);
        int c, first_c;
        logic done_next, holding, finished;
        logic [127:0] held_d;
        logic [3:0]   held_i;
        model_expand(kl, key);
        got_n = 0; c = 0; first_c = -1;
        done_next = 1'b0; holding = 1'b0; finished = 1'b0;
        held_d = '0; held_i = '0;
        key_len = kl; key_in = key; start = 1'b1;
        rk_ready = (mode == 0);
        @(posedge clk); #1;
        start = 1'b0;
        while (!finished && c < 800) begin
            chk("err_quiet", err, 0);
            if (done_next) begin
                chk("done_pulse", done, 1);
                chk("busy_at_done", busy, 0);
                chk("valid_at_done", rk_valid, 0);
                finished = 1'b1;
            end else begin
                chk("done_early", done, 0);
                chk("busy_run", busy, 1);
                if (rk_valid && first_c < 0) begin
                    first_c = c;
                    chk("first_valid_lat", 128'(c), 128'd4);
                end
                if (holding) begin
                    chk("hold_data", rk_data, held_d);
                    chk("hold_idx", rk_idx, held_i);
                end
                if (mode == 0) rk_ready = 1'b1;
                else if (mode == 1 && first_c >= 0 && c < first_c + 10) rk_ready = 1'b0;
                else rk_ready = 1'($urandom_range(0, 1));
                if (mode != 0) begin
                    start   = 1'($urandom_range(0, 1));
                    key_len = 2'($urandom_range(0, 3));
                    key_in  = {$urandom, $urandom, $urandom, $urandom,
                               $urandom, $urandom, $urandom, $urandom};
                end
                if (rk_valid && rk_ready) begin
                    if (got_n < exp_n) begin
                        chk("rk_data", rk_data, exp_keys[got_n]);
                        chk("rk_idx", rk_idx, 128'(got_n));
                        got_keys[got_n] = rk_data;
                    end
                    got_n++;
                    if (got_n == exp_n) begin
                        done_next = 1'b1;
                        start = 1'b0;
                    end
                    if (abort_k > 0 && got_n == abort_k) finished = 1'b1;
                end
                holding = rk_valid && !rk_ready;
                held_d  = rk_data;
                held_i  = rk_idx;
                if (!finished) begin
                    @(posedge clk); #1;
                    c++;
                end
            end
        end
        if (!finished) chk("timeout", 1, 0);
        start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        rk_ready = 1'b0; start = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    logic [255:0] k128, k192, k256, rkey;
    logic [127:0] lit;
    logic [1:0]   rkl;

    initial begin
        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
        rst_n = 1'b0; start = 1'b0; key_len = 2'b00; key_in = '0; rk_ready = 1'b0;
        build_sbox();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_outputs_zero("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(2);

        run_exp(2'b00, k128, 0, 0);
        chk("aes128_count", 128'(got_n), 128'd11);
        lit = 128'ha0fafe1788542cb123a339392a6c7605;
        chk("aes128_rk1", got_keys[1], lit);
        lit = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        chk("aes128_rk10", got_keys[10], lit);
        idle_cycles(2);

        run_exp(2'b01, k192, 0, 0);
        chk("aes192_count", 128'(got_n), 128'd13);
        lit = 128'he98ba06f448c773c8ecc720401002202;
        chk("aes192_rk12", got_keys[12], lit);
        idle_cycles(2);

        run_exp(2'b10, k256, 0, 0);
        chk("aes256_count", 128'(got_n), 128'd15);
        lit = 128'hfe4890d1e6188d0b046df344706c631e;
        chk("aes256_rk14", got_keys[14], lit);
        idle_cycles(2);

        run_exp(2'b00, k128, 1, 0);
        chk("bp_count", 128'(got_n), 128'd11);
        lit = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        chk("bp_rk10", got_keys[10], lit);
        idle_cycles(2);

        key_len = 2'b11; key_in = k256; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("ill_err", err, 1);
        chk("ill_busy", busy, 0);
        chk("ill_valid", rk_valid, 0);
        @(posedge clk); #1;
        chk("ill_err_clr", err, 0);
        chk("ill_busy2", busy, 0);
        chk("ill_valid2", rk_valid, 0);
        idle_cycles(2);

        run_exp(2'b10, k256, 0, 4);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk_outputs_zero("midreset");
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_cycles(1);
        run_exp(2'b00, k128, 0, 0);
        chk("post_rst_count", 128'(got_n), 128'd11);
        lit = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
        chk("post_rst_rk10", got_keys[10], lit);
        idle_cycles(2);

        for (int t = 0; t < 6; t++) begin
            rkl  = 2'($urandom_range(0, 2));
            rkey = {$urandom, $urandom, $urandom, $urandom,
                    $urandom, $urandom, $urandom, $urandom};
            run_exp(rkl, rkey, 2, 0);
            chk("rand_count", 128'(got_n), 128'(exp_n));
            idle_cycles(2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
